// File: rtl/rns_fwd_conv_seq.sv
// rns_fwd_conv_seq: sequential binary-to-RNS forward converter.
// Moduli set {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}. The operand is shifted out MSB
// first, and each lane performs a Horner step acc = (2*acc + b) mod m.
// The step needs at most one conditional subtraction, because 2*acc+b < 2*m.
module rns_fwd_conv_seq #(
   parameter int N  = 8,
   parameter int XW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] x,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  r1,
   output logic [N-1:0]  r2,
   output logic [N:0]    r3,
   output logic [N:0]    r4,
   output logic          busy
);

   // Working width for one lane step. Every acc is below 2^(N+1), so 2*acc+1
   // always fits in N+2 bits.
   localparam int AW = N + 2;
   localparam int CW = $clog2(XW + 1);

   localparam logic [AW-1:0] M1 = (AW'(1) << N) - AW'(1);
   localparam logic [AW-1:0] M3 = (AW'(1) << N) + AW'(1);
   localparam logic [AW-1:0] M4 = (AW'(1) << (N + 1)) - AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One Horner step of a modular lane: (2*acc + b) mod m.
   // The precondition acc < m limits the correction to a single subtraction.
   function automatic logic [AW-1:0] mod_step(input logic [AW-1:0] acc,
                                              input logic          b,
                                              input logic [AW-1:0] m);
      logic [AW-1:0] t;
      t = (acc << 1) + {{(AW-1){1'b0}}, b};
      if (t >= m) begin
         mod_step = t - m;
      end else begin
         mod_step = t;
      end
   endfunction

   state_t        state_q;
   logic [XW-1:0] sh_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  acc1_q, acc2_q;
   logic [N:0]    acc3_q, acc4_q;
   logic [N-1:0]  acc1_d, acc2_d;
   logic [N:0]    acc3_d, acc4_d;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          busy_q;
   logic          bit_s;

   // Next lane values computed from the current shift-register MSB.
   always_comb begin
      bit_s  = sh_q[XW-1];
      acc1_d = N'(mod_step(AW'(acc1_q), bit_s, M1));
      // The 2^N lane is a plain shift: the low N bits of the bit history.
      if (N > 1) begin
         acc2_d = {acc2_q[N-2:0], bit_s};
      end else begin
         acc2_d = N'(bit_s);
      end
      acc3_d = (N+1)'(mod_step(AW'(acc3_q), bit_s, M3));
      acc4_d = (N+1)'(mod_step(AW'(acc4_q), bit_s, M4));
   end

   // Control FSM, datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sh_q        <= '0;
         cnt_q       <= '0;
         acc1_q      <= '0;
         acc2_q      <= '0;
         acc3_q      <= '0;
         acc4_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  sh_q        <= x;
                  cnt_q       <= '0;
                  acc1_q      <= '0;
                  acc2_q      <= '0;
                  acc3_q      <= '0;
                  acc4_q      <= '0;
                  state_q     <= ST_BUSY;
                  in_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  out_valid_q <= 1'b0;
               end else begin
                  state_q     <= ST_IDLE;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b0;
               end
            end
            ST_BUSY: begin
               sh_q   <= {sh_q[XW-2:0], 1'b0};
               acc1_q <= acc1_d;
               acc2_q <= acc2_d;
               acc3_q <= acc3_d;
               acc4_q <= acc4_d;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == CW'(XW - 1)) begin
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b0;
               end else begin
                  state_q     <= ST_BUSY;
                  busy_q      <= 1'b1;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b0;
               end
            end
            ST_DONE: begin
               // Results stay in the accumulators until the consumer accepts them.
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign r1        = acc1_q;
   assign r2        = acc2_q;
   assign r3        = acc3_q;
   assign r4        = acc4_q;

endmodule

// File: tb/tb_rns_fwd_conv_seq.sv
// Testbench for rns_fwd_conv_seq. The expected residues come from plain modulo
// arithmetic on the operand.
module tb_rns_fwd_conv_seq;

   localparam int N  = 8;
   localparam int XW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [XW-1:0] x;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  r1, r2;
   logic [N:0]    r3, r4;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   rns_fwd_conv_seq #(.N(N), .XW(XW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .out_valid(out_valid), .out_ready(out_ready),
      .r1(r1), .r2(r2), .r3(r3), .r4(r4), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference residues of an operand, from plain modulo arithmetic.
   task automatic ref_res(input logic [XW-1:0] xv,
                          output logic [63:0] e1, output logic [63:0] e2,
                          output logic [63:0] e3, output logic [63:0] e4);
      logic [63:0] xx;
      xx = 64'(xv);
      e1 = xx % ((64'd1 << N) - 64'd1);
      e2 = xx % (64'd1 << N);
      e3 = xx % ((64'd1 << N) + 64'd1);
      e4 = xx % ((64'd1 << (N + 1)) - 64'd1);
   endtask

   task automatic chk_res(input string tag, input logic [XW-1:0] xv);
      logic [63:0] e1, e2, e3, e4;
      ref_res(xv, e1, e2, e3, e4);
      chk({tag, "_r1"}, 64'(r1), e1);
      chk({tag, "_r2"}, 64'(r2), e2);
      chk({tag, "_r3"}, 64'(r3), e3);
      chk({tag, "_r4"}, 64'(r4), e4);
   endtask

   // Runs one operand: handshake, latency check, residue check, an optional
   // hold with out_ready low, then the output handshake.
   task automatic do_op(input string tag, input logic [XW-1:0] xv, input int hold);
      int cyc;
      logic [N-1:0] h1;
      logic [N:0]   h4;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x         = xv;
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      x        = $urandom;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_inrdy_busy"}, 64'(in_ready), 64'd0);
      cyc = 1;
      while (!out_valid && cyc < XW + 20) begin
         @(negedge clk);
         cyc++;
         // Operand changes and stray in_valid pulses must be ignored.
         x        = $urandom;
         in_valid = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      chk({tag, "_latency"}, 64'(cyc), 64'(XW + 1));
      chk_res(tag, xv);
      chk({tag, "_inrdy_done"}, 64'(in_ready), 64'd0);
      h1 = r1;
      h4 = r4;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         x = $urandom;
         chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "_hold_inrdy"}, 64'(in_ready), 64'd0);
         chk({tag, "_hold_r1"}, 64'(r1), 64'(h1));
         chk({tag, "_hold_r4"}, 64'(r4), 64'(h4));
      end
      if (hold > 0) begin
         chk_res({tag, "_held"}, xv);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_idle_inrdy"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int          gap;
      bit          got;
      logic [N-1:0] c1, c2;
      logic [N:0]   c3, c4;
      logic [63:0]  e1, e2, e3, e4;
      logic [XW-1:0] rx;
      int          seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      repeat (3) @(negedge clk);
      chk("rst_inrdy", 64'(in_ready), 64'd1);
      chk("rst_outvalid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk_res("rst", '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed operands.
      do_op("zero", 32'd0, 0);
      do_op("ones", 32'hFFFF_FFFF, 2);
      do_op("k1000", 32'd1000, 0);
      do_op("k123456789", 32'd123456789, 10);

      // Back-to-back operands with in_valid held high and out_ready high.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x         = 32'd1000;
      @(posedge clk);
      @(negedge clk);
      x   = 32'd123456789;
      gap = 1;
      got = 1'b0;
      c1 = '0; c2 = '0; c3 = '0; c4 = '0;
      seen = 0;
      while (!in_ready && gap < 200) begin
         if (out_valid) begin
            seen++;
            if (!got) begin
               got = 1'b1;
               c1 = r1; c2 = r2; c3 = r3; c4 = r4;
            end
         end
         @(negedge clk);
         gap++;
      end
      chk("b2b_gap", 64'(gap), 64'(XW + 2));
      chk("b2b_outvalid_cycles", 64'(seen), 64'd1);
      ref_res(32'd1000, e1, e2, e3, e4);
      chk("b2b_first_r1", 64'(c1), e1);
      chk("b2b_first_r2", 64'(c2), e2);
      chk("b2b_first_r3", 64'(c3), e3);
      chk("b2b_first_r4", 64'(c4), e4);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      x        = $urandom;
      gap = 1;
      while (!out_valid && gap < XW + 20) begin
         @(negedge clk);
         gap++;
      end
      chk("b2b_second_latency", 64'(gap), 64'(XW + 1));
      chk_res("b2b_second", 32'd123456789);
      @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_idle_valid", 64'(out_valid), 64'd0);

      // Reset in the middle of an operation.
      @(negedge clk);
      in_valid = 1'b1;
      x        = 32'd1000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (15) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_inrdy", 64'(in_ready), 64'd1);
      chk("midrst_outvalid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk_res("midrst", '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < XW + 8; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      chk("midrst_no_output", 64'(seen), 64'd0);
      do_op("after_rst", 32'd1000, 1);

      // Random operands.
      for (int i = 0; i < 8; i++) begin
         rx = $urandom;
         if (i == 0) rx = 32'd1;
         if (i == 1) rx = 32'h8000_0000;
         do_op("rand", rx, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
